ahb_mem_responder: RTL and testbench

AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

---
 rtl/ahb_mem_responder.sv | 78 +++++++
 tb/tb_ahb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite word-wide memory slave with fixed wait states and two-cycle ERROR responses.
module ahb_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic pend, pend_nx;
  logic a_write;
  logic [AW-1:0] a_idx;
  logic [31:0] mem [DEPTH];
  logic [29:0] woff;
  logic accept, bad, final_ph;
  logic unused_ok;
  assign unused_ok = htrans[0];
  // word offset from the window base; addresses below the base wrap to huge values and fail the range test
  assign woff = haddr[31:2] - ADDR_BASE[31:2];
  assign bad = (haddr[1:0] != 2'b00) || (hsize != 3'b010) || (|woff[29:AW]);
  assign accept = hsel && htrans[1] && hready && hreadyout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      pend <= 1'b0;
      a_write <= 1'b0;
      a_idx <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      if (accept) begin
        a_write <= hwrite;
        a_idx <= woff[AW-1:0];
      end
    end
  end
  // pend marks a legal data phase in flight; with zero wait states it completes while still in IDLE
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    pend_nx = pend;
    if (state == ERR1)
      state_nx = ERR2;
    else if (state == WAIT && cnt != 4'd0)
      cnt_nx = cnt - 4'd1;
    else if (hready) begin
      state_nx = !accept ? IDLE : bad ? ERR1 : (WAIT_CYCLES > 0 ? WAIT : IDLE);
      cnt_nx = (accept && !bad) ? 4'(WAIT_CYCLES) : 4'd0;
      pend_nx = accept && !bad;
    end
  end
  always_comb begin
    hreadyout = !(state == ERR1 || (state == WAIT && cnt != 4'd0));
    hresp = state == ERR1 || state == ERR2;
    final_ph = pend && hreadyout;
    hrdata = (final_ph && !a_write) ? mem[a_idx] : 32'h0;
  end
  // the write lands at the edge ending its data phase, so a read accepted on that edge sees it
  always_ff @(posedge clk)
    if (!rst && final_ph && a_write && hready)
      mem[a_idx] <= hwdata;
endmodule

// File: tb/tb_ahb_mem_responder.sv
// tb_ahb_mem_responder: three responders (0, 1 and 3 wait states) driven by directed and random AHB traffic.
module tb_ahb_mem_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int D = 16;
  logic clk = 1'b0;
  logic [2:0] rst, hsel, hwrite, hready, hready_en, hreadyout, hresp;
  logic [2:0][1:0] htrans;
  logic [2:0][2:0] hsize;
  logic [2:0][31:0] haddr, hwdata, hrdata;
  int checks = 0;
  int errors = 0;
  int ws [3];
  logic [31:0] model [3][D];
  bit valid [3][D];
  always #5 clk = ~clk;
  assign hready = hreadyout & hready_en;
  ahb_mem_responder #(.ADDR_BASE(BASE), .DEPTH(D), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]), .hwrite(hwrite[0]),
    .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hready[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));
  ahb_mem_responder #(.ADDR_BASE(BASE), .DEPTH(D), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]), .hwrite(hwrite[1]),
    .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hready[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));
  ahb_mem_responder #(.ADDR_BASE(BASE), .DEPTH(D), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst[2]), .hsel(hsel[2]), .haddr(haddr[2]), .htrans(htrans[2]), .hwrite(hwrite[2]),
    .hsize(hsize[2]), .hwdata(hwdata[2]), .hready(hready[2]), .hreadyout(hreadyout[2]), .hresp(hresp[2]), .hrdata(hrdata[2]));

  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int cyc, output int nlow, output logic rf, output logic rl, output bit nz);
    rd = 32'hFFFF_FFFF; rf = 1'bx; rl = 1'bx; cyc = 0; nlow = 0; nz = 0;
    @(negedge clk);
    hsel[k] = 1'b1; htrans[k] = 2'd2; haddr[k] = a; hwrite[k] = wr; hsize[k] = sz;
    @(posedge clk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'd0; hwdata[k] = wd;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) rf = hresp[k];
      if (!hreadyout[k]) begin
        nlow++;
        if (hrdata[k] !== 32'h0) nz = 1;
      end else begin
        rd = hrdata[k];
        rl = hresp[k];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({hreadyout[k], hresp[k], hrdata[k]} !== {1'b1, 1'b0, 32'h0})
          $display("FAIL reset k=%0d c=%0d got rdy=%b resp=%b rdata=%h want 1/0/0", k, c, hreadyout[k], hresp[k], hrdata[k]);
        else continue;
        errors++;
      end
      if (c == 0) begin @(posedge clk); #1; rst = 3'b000; end
    end
  endtask

  task automatic test_wait_rw();
    logic [31:0] rd; int cyc, nlow; logic rf, rl; bit nz;
    xfer(0, 1, BASE + 8, 3'b010, 32'hDEADBEEF, rd, cyc, nlow, rf, rl, nz);
    model[0][2] = 32'hDEADBEEF; valid[0][2] = 1;
    checks++;
    if (cyc != 2 || nlow != 1 || rl !== 1'b0 || rf !== 1'b0) begin
      errors++; $display("FAIL wait_write got cyc=%0d low=%0d resp=%b/%b want 2/1/0/0", cyc, nlow, rf, rl);
    end
    xfer(0, 0, BASE + 8, 3'b010, 32'h0, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (cyc != 2 || nlow != 1 || rl !== 1'b0 || nz) begin
      errors++; $display("FAIL wait_read_timing got cyc=%0d low=%0d resp=%b nz=%0d want 2/1/0/0", cyc, nlow, rl, nz);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wait_read_data got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    hsel[1] = 1; htrans[1] = 2'd2; haddr[1] = BASE + 12; hwrite[1] = 1; hsize[1] = 3'b010;
    @(posedge clk); #1;
    hwdata[1] = 32'h1234_5678; hwrite[1] = 0;
    @(negedge clk);
    checks++;
    if ({hreadyout[1], hresp[1], hrdata[1]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL b2b_write got rdy=%b resp=%b rdata=%h want 1/0/0", hreadyout[1], hresp[1], hrdata[1]);
    end
    @(posedge clk); #1;
    hsel[1] = 0; htrans[1] = 2'd0;
    @(negedge clk);
    checks++;
    if ({hreadyout[1], hresp[1], hrdata[1]} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL b2b_read got rdy=%b resp=%b rdata=%h want 1/0/12345678", hreadyout[1], hresp[1], hrdata[1]);
    end
    @(posedge clk); #1;
    model[1][3] = 32'h1234_5678; valid[1][3] = 1;
  endtask

  task automatic test_oob_read();
    logic [31:0] rd; int cyc, nlow; logic rf, rl; bit nz;
    xfer(0, 0, BASE + D * 4, 3'b010, 32'h0, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (cyc != 2 || nlow != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      errors++; $display("FAIL oob_resp got cyc=%0d low=%0d resp=%b/%b want 2/1/1/1", cyc, nlow, rf, rl);
    end
    checks++;
    if (rd !== 32'h0 || nz) begin errors++; $display("FAIL oob_rdata got %h nz=%0d want 0", rd, nz); end
  endtask

  task automatic test_bad_write();
    logic [31:0] rd; int cyc, nlow; logic rf, rl; bit nz;
    xfer(0, 1, BASE + 9, 3'b010, 32'h0BAD_0001, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (cyc != 2 || nlow != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      errors++; $display("FAIL misalign_resp got cyc=%0d low=%0d resp=%b/%b want 2/1/1/1", cyc, nlow, rf, rl);
    end
    xfer(0, 1, BASE + 8, 3'b001, 32'h0BAD_0002, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (cyc != 2 || nlow != 1 || rf !== 1'b1 || rl !== 1'b1) begin
      errors++; $display("FAIL hsize_resp got cyc=%0d low=%0d resp=%b/%b want 2/1/1/1", cyc, nlow, rf, rl);
    end
    xfer(0, 0, BASE + 8, 3'b010, 32'h0, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (rd !== model[0][2] || rl !== 1'b0) begin
      errors++; $display("FAIL bad_write_kept got %h resp=%b want %h/0", rd, rl, model[0][2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int cyc, nlow; logic rf, rl; bit nz;
    xfer(2, 1, BASE + 4, 3'b010, 32'hCAFE_0001, rd, cyc, nlow, rf, rl, nz);
    model[2][1] = 32'hCAFE_0001; valid[2][1] = 1;
    checks++;
    if (cyc != 4 || nlow != 3) begin errors++; $display("FAIL w3_write got cyc=%0d low=%0d want 4/3", cyc, nlow); end
    @(negedge clk);
    hsel[2] = 1; htrans[2] = 2'd2; haddr[2] = BASE + 4; hwrite[2] = 1; hsize[2] = 3'b010;
    @(posedge clk); #1;
    hsel[2] = 0; htrans[2] = 2'd0; hwdata[2] = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if (hreadyout[2] !== 1'b0) begin errors++; $display("FAIL mid_wait1 got rdy=%b want 0", hreadyout[2]); end
    @(posedge clk); #1;
    rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    @(negedge clk);
    checks++;
    if ({hreadyout[2], hresp[2], hrdata[2]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL mid_reset got rdy=%b resp=%b rdata=%h want 1/0/0", hreadyout[2], hresp[2], hrdata[2]);
    end
    repeat (4) @(posedge clk);
    #1;
    xfer(2, 0, BASE + 4, 3'b010, 32'h0, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (rd !== 32'hCAFE_0001 || cyc != 4) begin
      errors++; $display("FAIL mid_reset_kept got %h cyc=%0d want cafe0001/4", rd, cyc);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] rd; int cyc, nlow; logic rf, rl; bit nz;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      hsel[0] = (m != 0); htrans[0] = (m == 1) ? 2'd1 : 2'd2; haddr[0] = BASE + 8; hwrite[0] = 1;
      hsize[0] = 3'b010; hwdata[0] = 32'h5555_AAAA; hready_en[0] = (m != 2);
      repeat (2) begin
        @(negedge clk);
        checks++;
        if ({hreadyout[0], hresp[0], hrdata[0]} !== {1'b1, 1'b0, 32'h0}) begin
          errors++; $display("FAIL ignore m=%0d got rdy=%b resp=%b rdata=%h want 1/0/0", m, hreadyout[0], hresp[0], hrdata[0]);
        end
      end
    end
    hsel[0] = 0; htrans[0] = 2'd0; hready_en[0] = 1;
    xfer(0, 0, BASE + 8, 3'b010, 32'h0, rd, cyc, nlow, rf, rl, nz);
    checks++;
    if (rd !== model[0][2]) begin errors++; $display("FAIL ignore_kept got %h want %h", rd, model[0][2]); end
  endtask

  task automatic test_random(input int k, input int n);
    bit cv, cw, ce, pv, pw, pe;
    int ci, pi, cc, done, guard, r, t;
    logic [31:0] pd, a, off, exp;
    logic [2:0] sz;
    cv = 0; ci = 0; cc = 0; cw = 0; ce = 0; pw = 0; pe = 0; pi = 0; pd = 0; done = 0; guard = 0;
    while ((done < n || cv) && guard < 5000) begin
      guard++;
      @(negedge clk);
      pv = 0;
      if (cv) begin
        cc++;
        if (hreadyout[k]) begin
          exp = (!cw && !ce) ? model[k][ci] : 32'h0;
          checks++;
          if (cc != (ce ? 2 : ws[k] + 1) || hresp[k] !== ce || hrdata[k] !== exp) begin
            errors++; $display("FAIL rnd k=%0d lat=%0d resp=%b rdata=%h want lat=%0d resp=%b rdata=%h",
                               k, cc, hresp[k], hrdata[k], ce ? 2 : ws[k] + 1, ce, exp);
          end
          if (cw && !ce) begin model[k][ci] = pd_hold(k); valid[k][ci] = 1; end
          cv = 0;
        end else begin
          checks++;
          if (hrdata[k] !== 32'h0 || hresp[k] !== ce) begin
            errors++; $display("FAIL rnd_wait k=%0d resp=%b rdata=%h want resp=%b rdata=0", k, hresp[k], hrdata[k], ce);
          end
        end
      end
      hsel[k] = 0; htrans[k] = 2'd0;
      if (hreadyout[k] && done < n) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin hsel[k] = 1; htrans[k] = 2'd1; end
        else if (r == 1) htrans[k] = 2'd2;
        else if (r > 2) begin
          t = $urandom_range(0, 9);
          pi = $urandom_range(0, D - 1);
          a = (t == 0) ? BASE + 4 * pi + $urandom_range(1, 3) :
              (t == 1) ? BASE + 4 * D + 4 * $urandom_range(0, 8) :
              (t == 2) ? BASE - 4 * $urandom_range(1, 8) : BASE + 4 * pi;
          t = $urandom_range(0, 6);
          sz = ($urandom_range(0, 7) == 0) ? 3'(t >= 2 ? t + 1 : t) : 3'b010;
          pw = $urandom_range(0, 1) == 1;
          off = a - BASE;
          pe = (a % 4 != 0) || (sz != 3'b010) || (off >= 4 * D);
          if (!pe) pi = off / 4;
          if (!pe && !pw && !valid[k][pi]) pw = 1;
          pd = $urandom;
          hsel[k] = 1; htrans[k] = 2'd2; haddr[k] = a; hwrite[k] = pw; hsize[k] = sz;
          pv = 1; done++;
        end
      end
      @(posedge clk); #1;
      if (pv) begin cv = 1; cw = pw; ce = pe; ci = pi; cc = 0; hwdata[k] = pd; end
      hsel[k] = 0; htrans[k] = 2'd0;
    end
    checks++;
    if (guard >= 5000) begin errors++; $display("FAIL rnd_timeout k=%0d done=%0d want %0d", k, done, n); end
  endtask

  function automatic logic [31:0] pd_hold(input int k);
    return hwdata[k];
  endfunction

  initial begin
    ws[0] = 1; ws[1] = 0; ws[2] = 3;
    for (int k = 0; k < 3; k++) for (int i = 0; i < D; i++) begin model[k][i] = 0; valid[k][i] = 0; end
    rst = 3'b111; hsel = 0; hwrite = 0; hready_en = 3'b111; htrans = '0; hsize = '0; haddr = '0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_wait_rw();
    test_back_to_back();
    test_oob_read();
    test_bad_write();
    test_reset_mid();
    test_ignore();
    for (int k = 0; k < 3; k++) test_random(k, 150);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
